// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and helper functions for the multi-channel PWM
//                controller: duty/channel width helpers, saturating duty
//                arithmetic and the button index enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   // Button index into the packed event/raw vectors of the top level
   typedef enum logic [1:0] {
      BTN_INC = 2'd0,
      BTN_DEC = 2'd1,
      BTN_SEL = 2'd2
   } btn_idx_e;

   localparam int NUM_BTN = 3;

   // Bits needed to hold a duty value in 0..period
   function automatic int f_duty_width(input int period);
      return $clog2(period + 1);
   endfunction

   // Bits needed to index num_ch channels, never less than one
   function automatic int f_ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Duty + step clamped to limit; the sum carries one bit of headroom so it
   // can never wrap before the clamp
   function automatic logic [31:0] f_sat_add(input logic [31:0] duty,
                                             input logic [31:0] step,
                                             input logic [31:0] limit);
      logic [32:0] w_sum;
      w_sum = {1'b0, duty} + {1'b0, step};
      return (w_sum > {1'b0, limit}) ? limit : w_sum[31:0];
   endfunction

   // Duty - step clamped at zero
   function automatic logic [31:0] f_sat_sub(input logic [31:0] duty,
                                             input logic [31:0] step);
      return (duty < step) ? 32'd0 : (duty - step);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_btn_debounce
//  Description : One push-button front end: 2-FF synchronizer, 2-deep sample
//                history advanced on the shared debounce tick, and a one-clock
//                press event on the 0,1,1 sample pattern. With
//                PWM_AUTOREPEAT_EN defined, a held button re-fires every
//                REPEAT_TICKS ticks (only for instances with REPEAT_EN set).
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_btn_debounce
`ifdef PWM_AUTOREPEAT_EN
#(
   parameter bit REPEAT_EN    = 1'b1,
   parameter int REPEAT_TICKS = 8
)
`endif
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_evt
);

   logic [1:0] r_sync;
   logic [1:0] r_hist;
   logic       w_sync;
   logic       w_press;

   assign w_sync = r_sync[1];

   // Bring the asynchronous button into the clk domain
   always_ff @(posedge clk) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], i_btn};
   end

   // Shift the synchronized level into the history once per debounce tick
   always_ff @(posedge clk) begin
      if (!rst_n)      r_hist <= 2'b00;
      else if (i_tick) r_hist <= {r_hist[0], w_sync};
   end

   // Fires once when the level has been seen high on two ticks after a low one
   assign w_press = i_tick & w_sync & r_hist[0] & ~r_hist[1];

`ifdef PWM_AUTOREPEAT_EN
   localparam int c_RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

   if (REPEAT_EN) begin : g_rep
      logic [c_RW-1:0] r_rep;
      logic            w_held;
      logic            w_rep_evt;

      assign w_held    = i_tick & w_sync & r_hist[0] & r_hist[1];
      assign w_rep_evt = w_held & (r_rep == c_RW'(REPEAT_TICKS - 1));

      // Count held ticks since the last event; any low sample stops repeating
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_rep <= '0;
         end else if (i_tick) begin
            if (w_press || !w_sync) r_rep <= '0;
            else if (w_held)        r_rep <= (r_rep == c_RW'(REPEAT_TICKS - 1)) ? '0
                                                                               : r_rep + c_RW'(1);
         end
      end

      assign o_evt = w_press | w_rep_evt;
   end else begin : g_no_rep
      assign o_evt = w_press;
   end
`else
   assign o_evt = w_press;
`endif

endmodule
`default_nettype wire

// File: rtl/pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_ctrl
//  Description : NUM_CH-channel PWM generator. Three debounced buttons step
//                the selected channel's shadow duty up/down (saturating) or
//                advance the selected channel. Shadow duties are copied into
//                the active duties on the last count of each period, so each
//                period is produced with a single, consistent duty.
//                Optional macro PWM_AUTOREPEAT_EN adds hold-to-repeat on the
//                increase/decrease buttons (and the REPEAT_TICKS parameter).
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_ctrl
   import pwm_pkg::*;
#(
   parameter int NUM_CH       = 2,
   parameter int PERIOD       = 10,
   parameter int STEP         = 1,
   parameter int DUTY_INIT    = 5,
   parameter int DEBOUNCE_DIV = 4
`ifdef PWM_AUTOREPEAT_EN
   ,
   parameter int REPEAT_TICKS = 8
`endif
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              btn_inc,
   input  logic                              btn_dec,
   input  logic                              btn_sel,
   output logic [NUM_CH-1:0]                 pwm_out,
   output logic [f_ch_width(NUM_CH)-1:0]     sel_ch,
   output logic [f_duty_width(PERIOD)-1:0]   sel_duty
);

   localparam int c_DW  = f_duty_width(PERIOD);
   localparam int c_CHW = f_ch_width(NUM_CH);
   localparam int c_CW  = $clog2(PERIOD);
   localparam int c_PW  = $clog2(DEBOUNCE_DIV);

   logic [c_PW-1:0]    r_presc;
   logic               w_tick;
   logic [c_CW-1:0]    r_cnt;
   logic               w_period_end;
   logic [c_CHW-1:0]   r_sel_ch;
   logic [NUM_BTN-1:0] w_btn_raw;
   logic [NUM_BTN-1:0] w_evt;
   logic               w_inc;
   logic               w_dec;
   logic [c_DW-1:0]    w_shadow [NUM_CH];

   assign w_btn_raw    = {btn_sel, btn_dec, btn_inc};
   assign w_tick       = (r_presc == c_PW'(DEBOUNCE_DIV - 1));
   assign w_period_end = (r_cnt == c_CW'(PERIOD - 1));

   // Simultaneous inc and dec cancel each other
   assign w_inc = w_evt[BTN_INC] & ~w_evt[BTN_DEC];
   assign w_dec = w_evt[BTN_DEC] & ~w_evt[BTN_INC];

   // Debounce sample-tick prescaler, shared by all buttons
   always_ff @(posedge clk) begin
      if (!rst_n)      r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + c_PW'(1);
   end

   // PWM period counter 0..PERIOD-1
   always_ff @(posedge clk) begin
      if (!rst_n)            r_cnt <= '0;
      else if (w_period_end) r_cnt <= '0;
      else                   r_cnt <= r_cnt + c_CW'(1);
   end

   for (genvar gb = 0; gb < NUM_BTN; gb++) begin : g_btn
      pwm_btn_debounce
`ifdef PWM_AUTOREPEAT_EN
      #(
         .REPEAT_EN    (gb != int'(BTN_SEL)),
         .REPEAT_TICKS (REPEAT_TICKS)
      )
`endif
      u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_tick (w_tick),
         .i_btn  (w_btn_raw[gb]),
         .o_evt  (w_evt[gb])
      );
   end

   // Channel select advances with wrap; a duty change in the same cycle still
   // lands on the old channel because the shadows compare against r_sel_ch
   always_ff @(posedge clk) begin
      if (!rst_n)              r_sel_ch <= '0;
      else if (w_evt[BTN_SEL]) r_sel_ch <= (r_sel_ch == c_CHW'(NUM_CH - 1)) ? '0
                                                                             : r_sel_ch + c_CHW'(1);
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [c_DW-1:0] r_shadow;
      logic [c_DW-1:0] r_active;
      logic            r_pwm;

      // Button-adjusted duty, only for the currently selected channel
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_shadow <= c_DW'(DUTY_INIT);
         end else if (r_sel_ch == c_CHW'(gi)) begin
            if (w_inc)      r_shadow <= c_DW'(f_sat_add(32'(r_shadow), 32'(STEP), 32'(PERIOD)));
            else if (w_dec) r_shadow <= c_DW'(f_sat_sub(32'(r_shadow), 32'(STEP)));
         end
      end

      // Adopt the shadow duty on the last count so the next period uses it
      always_ff @(posedge clk) begin
         if (!rst_n)            r_active <= c_DW'(DUTY_INIT);
         else if (w_period_end) r_active <= r_shadow;
      end

      // Registered compare keeps the output glitch-free
      always_ff @(posedge clk) begin
         if (!rst_n) r_pwm <= 1'b0;
         else        r_pwm <= (c_DW'(r_cnt) < r_active);
      end

      assign w_shadow[gi] = r_shadow;
      assign pwm_out[gi]  = r_pwm;
   end

   assign sel_ch   = r_sel_ch;
   assign sel_duty = w_shadow[r_sel_ch];

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_ctrl
//  Description : Directed self-checking bench for pwm_multi_ctrl with default
//                parameters. Hold-to-repeat checks follow PWM_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ctrl;

   localparam int NUM_CH = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              btn_inc;
   logic              btn_dec;
   logic              btn_sel;
   logic [NUM_CH-1:0] pwm_out;
   logic [0:0]        sel_ch;
   logic [3:0]        sel_duty;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;   // posedges since reset release

   pwm_multi_ctrl u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_inc  (btn_inc),
      .btn_dec  (btn_dec),
      .btn_sel  (btn_sel),
      .pwm_out  (pwm_out),
      .sel_ch   (sel_ch),
      .sel_duty (sel_duty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Counts high samples over one full PWM period (counter 0..9), starting at
   // the first negedge after the counter-0 output edge.
   task automatic measure(output int h0, output int h1);
      while (cyc % 10 != 1) @(negedge clk);
      h0 = 0;
      h1 = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
      end
   endtask

   // Hold the chosen buttons for 'hold' clocks, then release for 12 clocks
   task automatic press(input logic inc, input logic dec, input logic sel, input int hold);
      btn_inc = inc;
      btn_dec = dec;
      btn_sel = sel;
      repeat (hold) @(negedge clk);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      btn_sel = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      int h0, h1;
      rst_n = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_sel = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (pwm_out !== 2'b00) begin n_fail++; $display("FAIL reset_pwm: got %b expected 00", pwm_out); end
      n_checks++; if (sel_ch !== 1'b0) begin n_fail++; $display("FAIL reset_sel_ch: got %0d expected 0", sel_ch); end
      n_checks++; if (sel_duty !== 4'd5) begin n_fail++; $display("FAIL reset_sel_duty: got %0d expected 5", sel_duty); end
      rst_n = 1'b1;
      measure(h0, h1);
      n_checks++; if (h0 != 5) begin n_fail++; $display("FAIL init_duty_ch0: got %0d highs expected 5", h0); end
      n_checks++; if (h1 != 5) begin n_fail++; $display("FAIL init_duty_ch1: got %0d highs expected 5", h1); end
      n_checks++; if (sel_ch !== 1'b0 || sel_duty !== 4'd5) begin
         n_fail++; $display("FAIL post_reset_sel: got ch %0d duty %0d expected ch 0 duty 5", sel_ch, sel_duty);
      end
   endtask

   // Press lands mid-period: that period keeps 5/10, the next shows 6/10
   task automatic test_inc_boundary();
      int a0, a1, b0, b1;
      while (cyc % 20 != 1) @(negedge clk);
      fork
         begin measure(a0, a1); measure(b0, b1); end
         press(1'b1, 1'b0, 1'b0, 12);
      join
      n_checks++; if (sel_duty !== 4'd6) begin n_fail++; $display("FAIL inc_duty: got %0d expected 6", sel_duty); end
      n_checks++; if (a0 != 5) begin n_fail++; $display("FAIL inc_same_period: got %0d highs expected 5", a0); end
      n_checks++; if (b0 != 6) begin n_fail++; $display("FAIL inc_next_period: got %0d highs expected 6", b0); end
      n_checks++; if (a1 != 5 || b1 != 5) begin n_fail++; $display("FAIL inc_ch1_untouched: got %0d/%0d highs expected 5/5", a1, b1); end
   endtask

   // 3-clk toggling, phased so no two consecutive tick samples are both high
   task automatic test_bounce();
      int h0, h1;
      while (cyc % 20 != 2) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         btn_inc = ((i % 6) < 3);
         @(negedge clk);
      end
      btn_inc = 1'b0;
      repeat (16) @(negedge clk);
      n_checks++; if (sel_duty !== 4'd6) begin n_fail++; $display("FAIL bounce_duty: got %0d expected 6", sel_duty); end
      measure(h0, h1);
      n_checks++; if (h0 != 6) begin n_fail++; $display("FAIL bounce_pwm: got %0d highs expected 6", h0); end
   endtask

   task automatic test_saturation();
      int h0, h1;
      for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 12);
      n_checks++; if (sel_duty !== 4'd10) begin n_fail++; $display("FAIL sat_reach_max: got %0d expected 10", sel_duty); end
      for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 1'b0, 12);
      n_checks++; if (sel_duty !== 4'd10) begin n_fail++; $display("FAIL sat_hold_max: got %0d expected 10", sel_duty); end
      measure(h0, h1);
      n_checks++; if (h0 != 10) begin n_fail++; $display("FAIL full_duty_pwm: got %0d highs expected 10", h0); end
      n_checks++; if (h1 != 5) begin n_fail++; $display("FAIL full_duty_ch1: got %0d highs expected 5", h1); end
      for (int i = 0; i < 11; i++) press(1'b0, 1'b1, 1'b0, 12);
      n_checks++; if (sel_duty !== 4'd0) begin n_fail++; $display("FAIL sat_min: got %0d expected 0", sel_duty); end
      measure(h0, h1);
      n_checks++; if (h0 != 0) begin n_fail++; $display("FAIL zero_duty_pwm: got %0d highs expected 0", h0); end
   endtask

   task automatic test_select();
      press(1'b0, 1'b0, 1'b1, 12);
      n_checks++; if (sel_ch !== 1'b1 || sel_duty !== 4'd5) begin
         n_fail++; $display("FAIL sel_first: got ch %0d duty %0d expected ch 1 duty 5", sel_ch, sel_duty);
      end
      press(1'b0, 1'b0, 1'b1, 12);
      n_checks++; if (sel_ch !== 1'b0 || sel_duty !== 4'd0) begin
         n_fail++; $display("FAIL sel_wrap: got ch %0d duty %0d expected ch 0 duty 0", sel_ch, sel_duty);
      end
      press(1'b1, 1'b0, 1'b1, 12);
      n_checks++; if (sel_ch !== 1'b1 || sel_duty !== 4'd5) begin
         n_fail++; $display("FAIL sel_with_inc: got ch %0d duty %0d expected ch 1 duty 5", sel_ch, sel_duty);
      end
      press(1'b0, 1'b0, 1'b1, 12);
      n_checks++; if (sel_ch !== 1'b0 || sel_duty !== 4'd1) begin
         n_fail++; $display("FAIL sel_inc_old_ch: got ch %0d duty %0d expected ch 0 duty 1", sel_ch, sel_duty);
      end
      press(1'b1, 1'b1, 1'b0, 12);
      n_checks++; if (sel_duty !== 4'd1) begin n_fail++; $display("FAIL inc_dec_cancel: got %0d expected 1", sel_duty); end
   endtask

   // 104 held clocks = 26 tick samples of 1
   task automatic test_hold();
`ifdef PWM_AUTOREPEAT_EN
      for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 12);
      n_checks++; if (sel_duty !== 4'd5) begin n_fail++; $display("FAIL repeat_setup: got %0d expected 5", sel_duty); end
      press(1'b0, 1'b1, 1'b0, 104);
      n_checks++; if (sel_duty !== 4'd1) begin n_fail++; $display("FAIL repeat_dec: got %0d expected 1", sel_duty); end
      repeat (40) @(negedge clk);
      n_checks++; if (sel_duty !== 4'd1) begin n_fail++; $display("FAIL repeat_release: got %0d expected 1", sel_duty); end
`else
      press(1'b1, 1'b0, 1'b0, 104);
      n_checks++; if (sel_duty !== 4'd2) begin n_fail++; $display("FAIL long_hold_single: got %0d expected 2", sel_duty); end
`endif
   endtask

   // Reset asserted while channel 1 is high; outputs drop, duties restart at 5
   task automatic test_reset_mid();
      int h0, h1;
      while (cyc % 10 != 3) @(negedge clk);
      n_checks++; if (pwm_out[1] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_high: got %b expected 1", pwm_out[1]); end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (pwm_out !== 2'b00 || sel_duty !== 4'd5) begin
         n_fail++; $display("FAIL mid_reset: got pwm %b duty %0d expected pwm 00 duty 5", pwm_out, sel_duty);
      end
      rst_n = 1'b1;
      measure(h0, h1);
      n_checks++; if (h0 != 5 || h1 != 5) begin n_fail++; $display("FAIL mid_reset_period: got %0d/%0d highs expected 5/5", h0, h1); end
   endtask

   initial begin
      test_reset();
      test_inc_boundary();
      test_bounce();
      test_saturation();
      test_select();
      test_hold();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
Multi-channel PWM generator with parametrised period, channel count and duty step. Three debounced push-buttons (increase, decrease, channel-select) adjust each channel's duty cycle. Duty changes are shadowed and applied only at a period boundary, so outputs never glitch. Sits directly behind the ui_in button pins and drives uo_out PWM lines.

Parameters:
NUM_CH, 2, number of independent PWM channels (1..8)
PERIOD, 10, PWM period in clk cycles (>=2)
STEP, 1, duty increment/decrement per accepted press (1..PERIOD)
DUTY_INIT, 5, reset duty of every channel (0..PERIOD)
DEBOUNCE_DIV, 4, clk cycles per debounce sample tick (>=2; 25000000 on silicon)
REPEAT_TICKS, 8, ticks of continuous hold per auto-repeat event (used only with PWM_AUTOREPEAT_EN)

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  synchronous active-low reset
btn_inc  input  1  raw increase button, asynchronous
btn_dec  input  1  raw decrease button, asynchronous
btn_sel  input  1  raw channel-select button, asynchronous
pwm_out  output  NUM_CH  registered PWM outputs
sel_ch  output  clog2(NUM_CH) (min 1)  currently selected channel
sel_duty  output  DW=clog2(PERIOD+1)  shadow duty of selected channel

Behaviour:
- Reset (rst_n=0 at posedge clk): prescaler=0, period counter=0, pwm_out=0, sel_ch=0, all shadow and active duties=DUTY_INIT, sel_duty=DUTY_INIT, all debounce state=0.
- Prescaler counts 0..DEBOUNCE_DIV-1 and wraps. tick is high for one clk when count==DEBOUNCE_DIV-1.
- Each button passes through a 2-FF synchronizer clocked every clk, then a 2-bit sample history updated only on tick.
- On a tick cycle, press event = sync & hist[0] & ~hist[1], i.e. a sample pattern of 0,1,1 over three consecutive ticks. Event is a 1-clk pulse in that tick cycle.
- Release and bounce shorter than 2 ticks produce no event. One event per press.
- inc event: shadow[sel_ch] = min(shadow+STEP, PERIOD). Saturates; no wrap.
- dec event: shadow[sel_ch] = max(shadow-STEP, 0). Saturates; no underflow.
- inc and dec events in the same cycle: no change.
- sel event: sel_ch = sel_ch+1, wrapping NUM_CH-1 -> 0.
- sel and inc/dec in the same cycle: the duty change applies to the old sel_ch; the new sel_ch takes effect the next cycle.
- sel_duty = shadow[sel_ch], combinational from registers.
- Period counter counts 0..PERIOD-1 and wraps.
- When counter==PERIOD-1, every active[i] <= shadow[i], so new duties start at the counter=0 cycle.
- pwm_out[i] is registered: pwm_out[i] <= (cnt < active[i]). Output lags the counter by 1 clk.
- duty=0 gives a constant 0 output; duty=PERIOD gives a constant 1 output.
- Reset mid-period: outputs go to 0 on the reset edge. The first full period after reset uses DUTY_INIT.
- Arithmetic is done at DW+1 bits before saturation.

Optional Feature:
PWM_AUTOREPEAT_EN
- Defined: after an inc or dec event, if the button stays high, one further event is generated every REPEAT_TICKS ticks while the held sample remains 1. Events stop on the first 0 sample. Saturation rules are unchanged. btn_sel never auto-repeats.
- Undefined: exactly one event per press, and no repeat counter is synthesised.

Decomposition:
- Package pwm_pkg holds:
  - DW computation function (clog2 of PERIOD+1)
  - channel-index width function
  - duty saturating add/sub functions
  - enum for button index (BTN_INC, BTN_DEC, BTN_SEL)
- Sub-module pwm_btn_debounce (synchronizer + tick-sampled history + event pulse, plus the repeat counter under the macro), instantiated three times.
- Per-channel compare is a generate loop, not a sub-module.

Test Plan:
1. Reset with defaults -> pwm_out=0 during reset. Afterwards each channel is high 5 of every 10 clks, sel_ch=0, sel_duty=5.
2. btn_inc held high for 3 ticks (12 clks), then low -> exactly one event, sel_duty=6. Channel 0 changes to 6/10 only from the next counter=0 cycle; channel 1 stays at 5/10.
3. Bounce: btn_inc toggling every 3 clks for 40 clks -> no event, and duty unchanged.
4. 6 inc presses on channel 0 -> duty saturates at 10 and pwm_out[0] stays constant 1. Then 11 dec presses -> duty 0 and pwm_out[0] stays constant 0.
5. sel press ×2 with NUM_CH=2 -> sel_ch 0->1->0. Simultaneous sel+inc events -> channel 0 duty +1 and sel_ch becomes 1.
6. PWM_AUTOREPEAT_EN defined: btn_dec held for 2+3×8 ticks from duty 5 -> 4 events, duty=1. Release -> no further change.
